// File: rtl/input_cond_pkg.sv
// Shared types and constants for the board input conditioner.
// Holds the debounce FSM state encoding and the synchronizer depth.
package input_cond_pkg;

  typedef enum logic [1:0] {
    S_LO,
    S_RISE,
    S_HI,
    S_FALL
  } debounce_state_t;

  localparam int SYNC_STAGES = 2;

endpackage : input_cond_pkg

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchronizer, debounce FSM with stable-sample counter,
// and registered one-cycle press/release pulses.
module debounce_channel
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit ACCEPT_FIRST = (DEBOUNCE_CYCLES == 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  debounce_state_t state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             level_q, level_next;
  logic             press_q, press_next;
  logic             release_q, release_next;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      state     <= S_LO;
      cnt       <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], raw};
      state     <= state_next;
      cnt       <= cnt_next;
      level_q   <= level_next;
      press_q   <= press_next;
      release_q <= release_next;
    end
  end

  // cnt holds the number of stable samples already seen, so the sample being
  // evaluated now is number cnt+1; the change is accepted on sample DEBOUNCE_CYCLES.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    level_next   = level_q;
    press_next   = 1'b0;
    release_next = 1'b0;
    unique case (state)
      S_LO: begin
        if (s) begin
          if (ACCEPT_FIRST) begin
            state_next = S_HI;
            cnt_next   = '0;
            level_next = 1'b1;
            press_next = 1'b1;
          end else begin
            state_next = S_RISE;
            cnt_next   = CNT_W'(1);
          end
        end else begin
          cnt_next = '0;
        end
      end
      S_RISE: begin
        if (!s) begin
          state_next = S_LO;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = S_HI;
          cnt_next   = '0;
          level_next = 1'b1;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_HI: begin
        if (!s) begin
          if (ACCEPT_FIRST) begin
            state_next   = S_LO;
            cnt_next     = '0;
            level_next   = 1'b0;
            release_next = 1'b1;
          end else begin
            state_next = S_FALL;
            cnt_next   = CNT_W'(1);
          end
        end else begin
          cnt_next = '0;
        end
      end
      S_FALL: begin
        if (s) begin
          state_next = S_HI;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next   = S_LO;
          cnt_next     = '0;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = S_LO;
        cnt_next   = '0;
      end
    endcase
  end

  assign level         = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;

endmodule : debounce_channel

// File: rtl/input_conditioner.sv
// Cleans raw board inputs for processor_top: debounced buttons with press/release
// pulses, and synchronized (unfiltered) switches.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int NUM_BTN         = 2,
  parameter int SW_WIDTH        = 16,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTN-1:0]  btn_i,
  input  logic [SW_WIDTH-1:0] sw_i,
  output logic [NUM_BTN-1:0]  btn_level_o,
  output logic [NUM_BTN-1:0]  btn_press_o,
  output logic [NUM_BTN-1:0]  btn_release_o,
  output logic [SW_WIDTH-1:0] sw_o
);

  logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sync;

  for (genvar g = 0; g < NUM_BTN; g++) begin : gen_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .raw          (btn_i[g]),
      .level        (btn_level_o[g]),
      .press_pulse  (btn_press_o[g]),
      .release_pulse(btn_release_o[g])
    );
  end

  // Switches are slow, static settings, so synchronizing is enough.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_sync <= '0;
    end else begin
      sw_sync <= {sw_sync[SYNC_STAGES-2:0], sw_i};
    end
  end

  assign sw_o = sw_sync[SYNC_STAGES-1];

endmodule : input_conditioner
